// File: rtl/ifu_mt_if.sv
// Fetch-unit bundle: memory request/response, EXU redirect and decode handoff.
// master = fetch unit, slave = surrounding core/memory.
interface ifu_mt_if #(
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int ADDR_LEN    = 32
);
    localparam int TID_W = $clog2(NUM_THREADS);
    localparam int PC_W  = ADDR_LEN - 2;

    logic [NUM_THREADS-1:0] thread_en;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [ADDR_LEN-1:0]    mem_req_addr;
    logic [TID_W-1:0]       mem_req_tid;
    logic                   mem_rsp_valid;
    logic [TID_W-1:0]       mem_rsp_tid;
    logic [XLEN-1:0]        mem_rsp_data;
    logic                   redirect_valid;
    logic [TID_W-1:0]       redirect_tid;
    logic [PC_W-1:0]        redirect_pc;
    logic                   dec_valid;
    logic                   dec_ready;
    logic [XLEN-1:0]        dec_instr;
    logic [PC_W-1:0]        dec_pc;
    logic [TID_W-1:0]       dec_tid;

    modport master (
        input  thread_en,
        output mem_req_valid, input mem_req_ready, output mem_req_addr, output mem_req_tid,
        input  mem_rsp_valid, input mem_rsp_tid, input mem_rsp_data,
        input  redirect_valid, input redirect_tid, input redirect_pc,
        output dec_valid, input dec_ready, output dec_instr, output dec_pc, output dec_tid
    );

    modport slave (
        output thread_en,
        input  mem_req_valid, output mem_req_ready, input mem_req_addr, input mem_req_tid,
        output mem_rsp_valid, output mem_rsp_tid, output mem_rsp_data,
        output redirect_valid, output redirect_tid, output redirect_pc,
        input  dec_valid, output dec_ready, input dec_instr, input dec_pc, input dec_tid
    );
endinterface

// File: rtl/ifu_mt.sv
// Multi-thread fetch unit: per-thread PC + one-slot buffer, RR fetch issue, tagged responses, RR decode.
// Request registered (1 cycle after eligibility, locked until ready); decode path combinational from buffers.
module ifu_mt #(
    parameter int          NUM_THREADS  = 4,
    parameter int          XLEN         = 32,
    parameter int          ADDR_LEN     = 32,
    parameter int unsigned RESET_BASE   = 0,
    parameter int unsigned RESET_STRIDE = 'h2000
) (
    input  logic     clk,
    input  logic     rst,
    ifu_mt_if.master bus
);
    localparam int TID_W = $clog2(NUM_THREADS);
    localparam int PC_W  = ADDR_LEN - 2;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_WAIT_SQ, ST_HOLD} state_t;

    state_t            r_state     [NUM_THREADS];
    state_t            w_state_nx  [NUM_THREADS];
    logic [PC_W-1:0]   r_pc        [NUM_THREADS];
    logic [PC_W-1:0]   r_buf_pc    [NUM_THREADS];
    logic [XLEN-1:0]   r_buf_instr [NUM_THREADS];

    logic              r_req_vld;
    logic [TID_W-1:0]  r_req_tid;
    logic [PC_W-1:0]   r_req_pc;
    logic              r_req_stale;
    logic [TID_W-1:0]  r_req_ptr;
    logic [TID_W-1:0]  r_dec_ptr;

    logic [NUM_THREADS-1:0] w_rd, w_rsp, w_hs, w_req_elig, w_dec_elig, w_dec_take;
    logic              w_req_hs;
    logic [TID_W-1:0]  w_req_base, w_req_idx, w_req_win;
    logic              w_req_found;
    logic [TID_W-1:0]  w_dec_idx, w_dec_tid;
    logic              w_dec_vld;
    logic              w_rsp_bad;

    assign w_req_hs = r_req_vld && bus.mem_req_ready;

    always_comb begin
        w_rd       = '0;
        w_rsp      = '0;
        w_hs       = '0;
        w_req_elig = '0;
        w_dec_elig = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_rd[t]  = bus.redirect_valid && (bus.redirect_tid == TID_W'(t));
            w_rsp[t] = bus.mem_rsp_valid && (bus.mem_rsp_tid == TID_W'(t));
            w_hs[t]  = w_req_hs && (r_req_tid == TID_W'(t));
            // The thread owning the request register stays IDLE until its handshake, so exclude it.
            w_req_elig[t] = (r_state[t] == ST_IDLE) && bus.thread_en[t] && !w_rd[t]
                            && !(r_req_vld && (r_req_tid == TID_W'(t)));
            w_dec_elig[t] = (r_state[t] == ST_HOLD) && !w_rd[t];
        end
        w_rsp_bad = bus.mem_rsp_valid && (r_state[bus.mem_rsp_tid] != ST_WAIT)
                    && (r_state[bus.mem_rsp_tid] != ST_WAIT_SQ);
    end

    always_comb begin
        w_req_found = 1'b0;
        w_req_win   = '0;
        w_req_idx   = '0;
        w_req_base  = w_req_hs ? (r_req_tid + TID_W'(1)) : r_req_ptr;
        for (int i = 0; i < NUM_THREADS; i++) begin
            w_req_idx = w_req_base + TID_W'(i);
            if (!w_req_found && w_req_elig[w_req_idx]) begin
                w_req_found = 1'b1;
                w_req_win   = w_req_idx;
            end
        end
    end

    always_comb begin
        w_dec_vld  = 1'b0;
        w_dec_tid  = '0;
        w_dec_idx  = '0;
        w_dec_take = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            w_dec_idx = r_dec_ptr + TID_W'(i);
            if (!w_dec_vld && w_dec_elig[w_dec_idx]) begin
                w_dec_vld = 1'b1;
                w_dec_tid = w_dec_idx;
            end
        end
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_dec_take[t] = w_dec_vld && bus.dec_ready && (w_dec_tid == TID_W'(t));
        end
    end

    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_state_nx[t] = r_state[t];
            case (r_state[t])
                ST_IDLE:    if (w_hs[t]) w_state_nx[t] = (w_rd[t] || r_req_stale) ? ST_WAIT_SQ : ST_WAIT;
                ST_WAIT:    if (w_rsp[t]) w_state_nx[t] = w_rd[t] ? ST_IDLE : ST_HOLD;
                            else if (w_rd[t]) w_state_nx[t] = ST_WAIT_SQ;
                ST_WAIT_SQ: if (w_rsp[t]) w_state_nx[t] = ST_IDLE;
                ST_HOLD:    if (w_rd[t] || w_dec_take[t]) w_state_nx[t] = ST_IDLE;
                default:    w_state_nx[t] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            r_state[t] <= (!rst) ? ST_IDLE : w_state_nx[t];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_req_vld   <= 1'b0;
            r_req_tid   <= '0;
            r_req_pc    <= '0;
            r_req_stale <= 1'b0;
            r_req_ptr   <= '0;
            r_dec_ptr   <= '0;
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_pc[t]        <= PC_W'(RESET_BASE + RESET_STRIDE * t);
                r_buf_pc[t]    <= '0;
                r_buf_instr[t] <= '0;
            end
        end else begin
            if (!r_req_vld || bus.mem_req_ready) begin
                r_req_vld   <= w_req_found;
                r_req_stale <= 1'b0;
                if (w_req_found) begin
                    r_req_tid <= w_req_win;
                    r_req_pc  <= r_pc[w_req_win];
                end
            end else if (w_rd[r_req_tid]) begin
                // Locked request is not retracted; remember it now fetches a dead path.
                r_req_stale <= 1'b1;
            end
            if (w_req_hs) r_req_ptr <= r_req_tid + TID_W'(1);
            if (w_dec_vld && bus.dec_ready) r_dec_ptr <= w_dec_tid + TID_W'(1);
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (w_rd[t]) r_pc[t] <= bus.redirect_pc;
                else if (w_hs[t] && !r_req_stale) r_pc[t] <= r_pc[t] + PC_W'(1);
                if (w_hs[t]) r_buf_pc[t] <= r_req_pc;
                if (w_rsp[t] && (r_state[t] == ST_WAIT) && !w_rd[t]) r_buf_instr[t] <= bus.mem_rsp_data;
            end
        end
    end

    assign bus.mem_req_valid = r_req_vld;
    assign bus.mem_req_addr  = {r_req_pc, 2'b00};
    assign bus.mem_req_tid   = r_req_tid;
    assign bus.dec_valid     = w_dec_vld;
    assign bus.dec_instr     = w_dec_vld ? r_buf_instr[w_dec_tid] : '0;
    assign bus.dec_pc        = w_dec_vld ? r_buf_pc[w_dec_tid] : '0;
    assign bus.dec_tid       = w_dec_vld ? w_dec_tid : '0;

    // Responses are only legal for threads with a fetch outstanding.
    a_rsp_legal: assert property (@(posedge clk) disable iff (!rst) !w_rsp_bad);
endmodule

// File: tb/tb_ifu_mt.sv
// Randomised + directed bench for ifu_mt: memory responder model, per-thread program-order scoreboard.
module tb_ifu_mt;
    localparam int NT = 4;
    localparam int XL = 32;
    localparam int AL = 32;
    localparam int TW = 2;
    localparam int PW = 30;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ifu_mt_if #(.NUM_THREADS(NT), .XLEN(XL), .ADDR_LEN(AL)) bus ();
    ifu_mt #(.NUM_THREADS(NT), .XLEN(XL), .ADDR_LEN(AL), .RESET_BASE(0), .RESET_STRIDE('h2000))
        dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {int tid; logic [31:0] addr; int due;} pend_t;
    typedef struct {int tid; logic [31:0] addr;} req_t;
    typedef struct {int tid; logic [PW-1:0] pc;} dec_t;

    pend_t           pend[$];
    req_t            req_log[$];
    dec_t            dec_log[$];
    logic [PW-1:0]   exp_q[NT][$];
    int              n_cmp = 0;
    int              n_bad = 0;
    int              cyc = 0;
    int              lat_max = 0;
    logic [NT-1:0]   rsp_block = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit pend_has(int tid);
        foreach (pend[i]) if (pend[i].tid == tid) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int next_req(int from, int tid);
        for (int i = from; i < req_log.size(); i++) if (req_log[i].tid == tid) return i;
        return -1;
    endfunction

    function automatic int next_dec(int from, int tid);
        for (int i = from; i < dec_log.size(); i++) if (dec_log[i].tid == tid) return i;
        return -1;
    endfunction

    function automatic int count_req(int from, int tid);
        int n = 0;
        for (int i = from; i < req_log.size(); i++) if (req_log[i].tid == tid) n++;
        return n;
    endfunction

    // Monitor: records handshakes seen just before each rising edge and scores decode output.
    initial begin
        bit prev_stall;
        logic [31:0] prev_addr;
        int prev_tid;
        int t;
        logic [PW-1:0] e;
        prev_stall = 1'b0;
        prev_addr = '0;
        prev_tid = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("req_hold_valid", 64'(bus.mem_req_valid), 64'(1));
                check("req_hold_addr", 64'(bus.mem_req_addr), 64'(prev_addr));
                check("req_hold_tid", 64'(bus.mem_req_tid), 64'(prev_tid));
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                req_log.push_back('{int'(bus.mem_req_tid), bus.mem_req_addr});
                pend.push_back('{int'(bus.mem_req_tid), bus.mem_req_addr,
                                 cyc + 1 + int'($urandom_range(lat_max))});
            end
            prev_stall = bus.mem_req_valid && !bus.mem_req_ready;
            prev_addr  = bus.mem_req_addr;
            prev_tid   = int'(bus.mem_req_tid);
            if (bus.dec_valid && bus.dec_ready) begin
                t = int'(bus.dec_tid);
                dec_log.push_back('{t, bus.dec_pc});
                if (exp_q[t].size() == 0) begin
                    check("dec_unexpected", 64'(1), 64'(0));
                end else begin
                    e = exp_q[t].pop_front();
                    check("dec_pc", 64'(bus.dec_pc), 64'(e));
                    check("dec_instr", 64'(bus.dec_instr), 64'(mem_word({e, 2'b00})));
                    exp_q[t].push_back(e + PW'(1));
                end
            end
            if (bus.redirect_valid) begin
                t = int'(bus.redirect_tid);
                exp_q[t].delete();
                exp_q[t].push_back(bus.redirect_pc);
            end
        end
    end

    // Memory: answers each accepted fetch once, after its latency, in random order across threads.
    initial begin
        int cand[$];
        int k;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_tid   = '0;
        bus.mem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.mem_rsp_valid = 1'b0;
            if (!rst) begin
                pend.delete();
                continue;
            end
            cand.delete();
            foreach (pend[i]) if (pend[i].due <= cyc && !rsp_block[pend[i].tid]) cand.push_back(i);
            if (cand.size() > 0) begin
                k = cand[$urandom_range(cand.size() - 1)];
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_tid   = TW'(pend[k].tid);
                bus.mem_rsp_data  = mem_word(pend[k].addr);
                pend.delete(k);
            end
        end
    end

    initial begin
        #400000;
        n_bad++;
        $display("FAIL watchdog: got timeout, required run completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int n, n2, j, i5, cnt;
        bit found;
        for (int t = 0; t < NT; t++) exp_q[t].push_back(PW'(t * 'h2000));
        bus.thread_en      = 4'hF;
        bus.mem_req_ready  = 1'b1;
        bus.dec_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_tid   = '0;
        bus.redirect_pc    = '0;

        // Reset state and first round of fetches
        step(); step();
        @(negedge clk);
        check("rst_req_valid", 64'(bus.mem_req_valid), 64'(0));
        check("rst_req_addr", 64'(bus.mem_req_addr), 64'(0));
        check("rst_req_tid", 64'(bus.mem_req_tid), 64'(0));
        check("rst_dec_valid", 64'(bus.dec_valid), 64'(0));
        check("rst_dec_instr", 64'(bus.dec_instr), 64'(0));
        check("rst_dec_pc_tid", 64'({bus.dec_pc, bus.dec_tid}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (30) step();
        check("t1_req_count", 64'(req_log.size() >= 4), 64'(1));
        check("t1_dec_count", 64'(dec_log.size() >= 4), 64'(1));
        for (int i = 0; i < 4; i++) begin
            if (i < req_log.size()) begin
                check("t1_req_tid", 64'(req_log[i].tid), 64'(i));
                check("t1_req_addr", 64'(req_log[i].addr), 64'(i * 'h8000));
            end
            if (i < dec_log.size()) check("t1_dec_tid", 64'(dec_log[i].tid), 64'(i));
        end

        // Decode backpressure fills every buffer, then drains in round-robin order
        bus.dec_ready = 1'b0;
        repeat (10) step();
        @(negedge clk);
        n = req_log.size();
        step(); step();
        @(negedge clk);
        check("t4_req_quiet", 64'(req_log.size()), 64'(n));
        check("t4_req_valid_low", 64'(bus.mem_req_valid), 64'(0));
        check("t4_dec_valid", 64'(bus.dec_valid), 64'(1));
        n = dec_log.size();
        @(posedge clk); #1;
        bus.dec_ready = 1'b1;
        repeat (6) step();
        check("t4_drain_count", 64'(dec_log.size() >= n + 4), 64'(1));
        for (int i = 0; i < 3; i++)
            if (n + i + 1 < dec_log.size())
                check("t4_dec_rr", 64'(dec_log[n + i + 1].tid), 64'((dec_log[n + i].tid + 1) % NT));

        // Memory stall: request must hold until accepted, then be taken exactly once
        bus.mem_req_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            found = bus.mem_req_valid;
        end
        check("t2_req_seen", 64'(found), 64'(1));
        begin
            logic [31:0] a0;
            int t0;
            a0 = bus.mem_req_addr;
            t0 = int'(bus.mem_req_tid);
            n = req_log.size();
            repeat (3) begin
                step();
                @(negedge clk);
                check("t2_stall_addr", 64'(bus.mem_req_addr), 64'(a0));
                check("t2_stall_tid", 64'(bus.mem_req_tid), 64'(t0));
            end
            @(posedge clk); #1;
            bus.mem_req_ready = 1'b1;
            repeat (4) step();
            cnt = 0;
            for (int i = n; i < req_log.size(); i++) if (req_log[i].addr == a0 && req_log[i].tid == t0) cnt++;
            check("t2_one_handshake", 64'(cnt), 64'(1));
            if (n < req_log.size()) check("t2_first_after_stall", 64'(req_log[n].addr), 64'(a0));
        end

        // Redirect a thread whose fetch is in flight
        rsp_block[1] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            found = pend_has(1);
        end
        check("t3_tid1_waiting", 64'(found), 64'(1));
        bus.redirect_valid = 1'b1;
        bus.redirect_tid   = 2'd1;
        bus.redirect_pc    = PW'('h100);
        n  = req_log.size();
        n2 = dec_log.size();
        step();
        bus.redirect_valid = 1'b0;
        step(); step();
        rsp_block[1] = 1'b0;
        repeat (12) step();
        j = next_req(n, 1);
        check("t3_req_found", 64'(j >= 0), 64'(1));
        if (j >= 0) check("t3_req_addr", 64'(req_log[j].addr), 64'(32'h400));
        j = next_dec(n2, 1);
        check("t3_dec_found", 64'(j >= 0), 64'(1));
        if (j >= 0) check("t3_dec_pc", 64'(dec_log[j].pc), 64'(PW'('h100)));

        // PC wrap at the top of the word address space
        bus.redirect_valid = 1'b1;
        bus.redirect_tid   = 2'd0;
        bus.redirect_pc    = '1;
        n = req_log.size();
        step();
        bus.redirect_valid = 1'b0;
        repeat (20) step();
        i5 = -1;
        for (int i = n; i < req_log.size(); i++)
            if (i5 < 0 && req_log[i].tid == 0 && req_log[i].addr == 32'hFFFF_FFFC) i5 = i;
        check("t5_top_fetch", 64'(i5 >= 0), 64'(1));
        if (i5 >= 0) begin
            j = next_req(i5 + 1, 0);
            check("t5_wrap_found", 64'(j >= 0), 64'(1));
            if (j >= 0) check("t5_wrap_addr", 64'(req_log[j].addr), 64'(0));
        end

        // Redirect and matching response in the same cycle
        bus.thread_en = 4'b0001;
        repeat (10) step();
        rsp_block[0] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            found = (pend.size() == 1) && pend_has(0);
        end
        check("t5_tid0_alone_waiting", 64'(found), 64'(1));
        bus.redirect_valid = 1'b1;
        bus.redirect_tid   = 2'd0;
        bus.redirect_pc    = PW'('h200);
        rsp_block[0] = 1'b0;
        n  = req_log.size();
        n2 = dec_log.size();
        step();
        bus.redirect_valid = 1'b0;
        check("t5_rsp_same_cycle", 64'(pend.size()), 64'(0));
        repeat (10) step();
        j = next_req(n, 0);
        check("t5_req_found", 64'(j >= 0), 64'(1));
        if (j >= 0) check("t5_req_addr", 64'(req_log[j].addr), 64'(32'h800));
        j = next_dec(n2, 0);
        check("t5_dec_found", 64'(j >= 0), 64'(1));
        if (j >= 0) check("t5_dec_pc", 64'(dec_log[j].pc), 64'(PW'('h200)));

        // Thread enable: disabled thread stays silent; a disabled thread still drains its fetch
        bus.thread_en = 4'b1011;
        lat_max = 3;
        repeat (3) step();
        n = req_log.size();
        repeat (150) begin
            bus.mem_req_ready = ($urandom_range(3) != 0);
            bus.dec_ready     = ($urandom_range(2) != 0);
            step();
        end
        check("t6_tid2_silent", 64'(count_req(n, 2)), 64'(0));
        bus.mem_req_ready = 1'b1;
        bus.dec_ready     = 1'b1;
        lat_max = 0;
        rsp_block[0] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            found = pend_has(0);
        end
        check("t6_tid0_waiting", 64'(found), 64'(1));
        bus.thread_en = 4'b1010;
        n  = req_log.size();
        n2 = dec_log.size();
        rsp_block[0] = 1'b0;
        repeat (20) step();
        cnt = 0;
        for (int i = n2; i < dec_log.size(); i++) if (dec_log[i].tid == 0) cnt++;
        check("t6_tid0_drained", 64'(cnt), 64'(1));
        check("t6_tid0_silent", 64'(count_req(n, 0)), 64'(0));

        // Random traffic with redirects, backpressure and out-of-order memory latency
        lat_max = 4;
        n2 = dec_log.size();
        repeat (600) begin
            bus.thread_en     = NT'($urandom);
            bus.mem_req_ready = ($urandom_range(3) != 0);
            bus.dec_ready     = ($urandom_range(2) != 0);
            bus.redirect_valid = ($urandom_range(11) == 0);
            bus.redirect_tid   = TW'($urandom_range(NT - 1));
            bus.redirect_pc    = PW'($urandom_range('h3FFF));
            step();
        end
        check("rand_progress", 64'(dec_log.size() - n2 > 50), 64'(1));

        bus.thread_en      = '0;
        bus.redirect_valid = 1'b0;
        bus.mem_req_ready  = 1'b1;
        bus.dec_ready      = 1'b1;
        repeat (40) step();
        @(negedge clk);
        check("drain_req_valid", 64'(bus.mem_req_valid), 64'(0));
        check("drain_dec_valid", 64'(bus.dec_valid), 64'(0));
        check("drain_mem_empty", 64'(pend.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
